l2_burst_adapter: RTL

L2_BURST_ADAPTER -- requirements
Module: l2_burst_adapter

---
 rtl/l2_burst_adapter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/l2_burst_adapter.sv
// rtl/l2_burst_adapter.sv - converts L2 line read/write requests into 4-beat memory bursts
// Registered-output FSM; one completion pulse per line after the final beat.
module l2_burst_adapter #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         line_addr,
    input  logic                line_read,
    input  logic                line_write,
    input  logic [s_line-1:0]   line_wdata,
    output logic [s_line-1:0]   line_rdata,
    output logic                line_resp,
    output logic [31:0]         burst_addr,
    output logic                burst_read,
    output logic                burst_write,
    output logic [s_burst-1:0]  burst_wdata,
    input  logic [s_burst-1:0]  burst_rdata,
    input  logic                burst_resp
);

    localparam int n_beats = s_line / s_burst;
    localparam int cnt_w   = $clog2(n_beats);
    localparam int off_w   = $clog2(s_line / 8);
    localparam logic [cnt_w-1:0] last_beat = cnt_w'(n_beats - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [cnt_w-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [s_line-1:0]   line_rdata_q, line_rdata_d;
    logic [s_line-1:0]   wbuf_q, wbuf_d;
    logic                line_resp_q, line_resp_d;
    logic [31:0]         burst_addr_q, burst_addr_d;
    logic                burst_read_q, burst_read_d;
    logic                burst_write_q, burst_write_d;
    logic [s_burst-1:0]  burst_wdata_q, burst_wdata_d;

    // Byte-offset bits inside a line never reach memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^line_addr[off_w-1:0];

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        line_rdata_d  = line_rdata_q;
        wbuf_d        = wbuf_q;
        line_resp_d   = 1'b0;
        burst_addr_d  = burst_addr_q;
        burst_read_d  = burst_read_q;
        burst_write_d = burst_write_q;
        burst_wdata_d = burst_wdata_q;
        case (state_q)
            IDLE: begin
                // Write-back wins over fill when both are requested.
                if (line_read || line_write) begin
                    burst_addr_d = {line_addr[31:off_w], {off_w{1'b0}}};
                    cnt_d        = '0;
                    if (line_write) begin
                        state_d       = WRITE;
                        burst_write_d = 1'b1;
                        wbuf_d        = line_wdata;
                        burst_wdata_d = line_wdata[s_burst-1:0];
                    end else begin
                        state_d      = READ;
                        burst_read_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (burst_resp) begin
                    line_rdata_d[cnt_q*s_burst +: s_burst] = burst_rdata;
                    cnt_d = cnt_inc;
                    if (cnt_q == last_beat) begin
                        state_d      = DONE;
                        burst_read_d = 1'b0;
                        line_resp_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    cnt_d         = cnt_inc;
                    burst_wdata_d = wbuf_q[cnt_inc*s_burst +: s_burst];
                    if (cnt_q == last_beat) begin
                        state_d       = DONE;
                        burst_write_d = 1'b0;
                        line_resp_d   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            line_rdata_q  <= '0;
            wbuf_q        <= '0;
            line_resp_q   <= 1'b0;
            burst_addr_q  <= '0;
            burst_read_q  <= 1'b0;
            burst_write_q <= 1'b0;
            burst_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            line_rdata_q  <= line_rdata_d;
            wbuf_q        <= wbuf_d;
            line_resp_q   <= line_resp_d;
            burst_addr_q  <= burst_addr_d;
            burst_read_q  <= burst_read_d;
            burst_write_q <= burst_write_d;
            burst_wdata_q <= burst_wdata_d;
        end
    end

    assign line_rdata  = line_rdata_q;
    assign line_resp   = line_resp_q;
    assign burst_addr  = burst_addr_q;
    assign burst_read  = burst_read_q;
    assign burst_write = burst_write_q;
    assign burst_wdata = burst_wdata_q;

endmodule
